image_control: RTL and testbench

Window-formation stage between the AXI-stream pixel input and the 3x3 convolution/filter core of the edge-detection pipeline. It accepts a raster stream of 8-bit pixels and writes them round-robin into four single-line buffers. Once three full lines are resident, it reads them out in lock-step to present one 3x3 pixel neighbourhood per cycle. It also pulses an interrupt each time a line has been consumed, so the DMA can supply the next line.

---
 rtl/image_control_pkg.sv | 30 +++
 rtl/image_control_line_buf.sv | 57 +++++
 rtl/image_control.sv | 174 +++++++++++++++++
 tb/tb_image_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/image_control_pkg.sv
// Shared constants, FSM state type and width helpers for the image_control
// window-formation stage and its line buffers.
package image_control_pkg;

   // Default geometry: 512 pixels per line, 8-bit pixels.
   localparam int DEF_IMG_WIDTH = 512;
   localparam int DEF_PIX_W     = 8;

   // Four single-line buffers are used round-robin; three of them form a window.
   localparam int NUM_LINES = 4;
   localparam int WIN_LINES = 3;
   localparam int SEL_W     = $clog2(NUM_LINES);

   // Read-side FSM: waiting for three resident lines, or streaming one line out.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_READ = 1'b1
   } rd_state_t;

   // Column pointer width for a line of 'width' pixels (width is a power of two).
   function automatic int ptr_width(input int width);
      return $clog2(width);
   endfunction

   // Fill-count width able to hold 0..NUM_LINES*width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(NUM_LINES * width + 1);
   endfunction

endpackage

// File: rtl/image_control_line_buf.sv
// One line of pixel storage with independent write and read pointers and a
// combinational three-pixel window starting at the read pointer.
module image_control_line_buf
   import image_control_pkg::*;
#(
   parameter int IMG_WIDTH = DEF_IMG_WIDTH,
   parameter int PIX_W     = DEF_PIX_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PIX_W-1:0]       i_data,
   input  logic                   i_valid,
   input  logic                   i_rd_en,
   output logic [3*PIX_W-1:0]     o_window
);

   localparam int               PTR_W   = ptr_width(IMG_WIDTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

   logic [PIX_W-1:0] r_mem [IMG_WIDTH];
   logic [PTR_W-1:0] r_wp;
   logic [PTR_W-1:0] r_rp;
   logic [PTR_W-1:0] w_rp1;
   logic [PTR_W-1:0] w_rp2;

   // Pixel store; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (i_valid) begin
         r_mem[r_wp] <= i_data;
      end
   end

   // Write pointer follows accepted pixels and wraps at the end of the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp <= '0;
      end else if (i_valid) begin
         r_wp <= r_wp + PTR_ONE;
      end
   end

   // Read pointer advances once per window while this buffer is selected.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rp <= '0;
      end else if (i_rd_en) begin
         r_rp <= r_rp + PTR_ONE;
      end
   end

   // Neighbour columns wrap naturally because the pointer width matches the line.
   assign w_rp1    = r_rp + PTR_ONE;
   assign w_rp2    = r_rp + PTR_TWO;
   assign o_window = {r_mem[r_rp], r_mem[w_rp1], r_mem[w_rp2]};

endmodule

// File: rtl/image_control.sv
// Window-formation stage: writes a raster pixel stream round-robin into four
// line buffers and, once three lines are resident, emits one 3x3 window per
// cycle for a whole line, then pulses intr to release a buffer.
//
// Handshake: pixel_in is taken on every cycle pixel_in_valid is high unless all
// four buffers are full (then it is dropped and overflow latches); the output
// has no ready - pixel_out is meaningful exactly when pixel_out_valid is high
// and is held at zero otherwise.
module image_control
   import image_control_pkg::*;
#(
   parameter int IMG_WIDTH = DEF_IMG_WIDTH,
   parameter int PIX_W     = DEF_PIX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PIX_W-1:0]     pixel_in,
   input  logic                 pixel_in_valid,
   output logic [9*PIX_W-1:0]   pixel_out,
   output logic                 pixel_out_valid,
   output logic                 intr,
   output logic                 overflow
);

   localparam int               PTR_W    = ptr_width(IMG_WIDTH);
   localparam int               CNT_W    = cnt_width(IMG_WIDTH);
   localparam int               WIN_W    = 3 * PIX_W;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(NUM_LINES * IMG_WIDTH);
   localparam logic [CNT_W-1:0] READ_LVL = CNT_W'(WIN_LINES * IMG_WIDTH);
   localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_TWO  = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_SKIP = SEL_W'(3);

   // Registered state
   rd_state_t        r_state;
   logic [PTR_W-1:0] r_wr_cnt;
   logic [SEL_W-1:0] r_wr_sel;
   logic [PTR_W-1:0] r_rd_cnt;
   logic [SEL_W-1:0] r_rd_sel;
   logic [CNT_W-1:0] r_total_pix;
   logic             r_intr;
   logic             r_overflow;

   // Combinational helpers
   logic                 w_rd;
   logic                 w_full;
   logic                 w_wr;
   logic                 w_drop;
   logic [NUM_LINES-1:0] w_buf_valid;
   logic [NUM_LINES-1:0] w_buf_rd_en;
   logic [WIN_W-1:0]     w_win [NUM_LINES];
   logic [SEL_W-1:0]     w_sel_mid;
   logic [SEL_W-1:0]     w_sel_bot;
   logic [SEL_W-1:0]     w_sel_idle;

   // A read consumes one slot every cycle of READ, so a write in that cycle
   // always has room even when the count sits at the maximum.
   assign w_rd   = (r_state == ST_READ);
   assign w_full = (r_total_pix == FULL_LVL) && !w_rd;
   assign w_wr   = pixel_in_valid && !w_full;
   assign w_drop = pixel_in_valid && w_full;

   // The three lines of the window, top to bottom; the fourth buffer is the
   // one currently being refilled and keeps its read pointer still.
   assign w_sel_mid  = r_rd_sel + SEL_ONE;
   assign w_sel_bot  = r_rd_sel + SEL_TWO;
   assign w_sel_idle = r_rd_sel + SEL_SKIP;

   // Route the accepted pixel only to the buffer currently being written.
   always_comb begin
      w_buf_valid           = '0;
      w_buf_valid[r_wr_sel] = w_wr;
   end

   // Advance the read pointers of the three window buffers while reading.
   always_comb begin
      w_buf_rd_en = '0;
      for (int b = 0; b < NUM_LINES; b++) begin
         w_buf_rd_en[b] = w_rd && (SEL_W'(b) != w_sel_idle);
      end
   end

   for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
      image_control_line_buf #(
         .IMG_WIDTH (IMG_WIDTH),
         .PIX_W     (PIX_W)
      ) u_line_buf (
         .clk      (clk),
         .rst      (rst),
         .i_data   (pixel_in),
         .i_valid  (w_buf_valid[g]),
         .i_rd_en  (w_buf_rd_en[g]),
         .o_window (w_win[g])
      );
   end

   // Write-side column counter and target-buffer selector.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_cnt <= '0;
         r_wr_sel <= '0;
      end else if (w_wr) begin
         if (r_wr_cnt == LAST_COL) begin
            r_wr_cnt <= '0;
            r_wr_sel <= r_wr_sel + SEL_ONE;
         end else begin
            r_wr_cnt <= r_wr_cnt + PTR_ONE;
         end
      end
   end

   // Number of stored pixels not yet consumed by a read.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_total_pix <= '0;
      end else if (w_wr && !w_rd) begin
         r_total_pix <= r_total_pix + CNT_ONE;
      end else if (!w_wr && w_rd) begin
         r_total_pix <= r_total_pix - CNT_ONE;
      end
   end

   // Sticky flag for any pixel lost while all buffers were full.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   // Read FSM: stream one full line of windows, then release a buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_rd_cnt <= '0;
         r_rd_sel <= '0;
         r_intr   <= 1'b0;
      end else begin
         r_intr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_total_pix >= READ_LVL) begin
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (r_rd_cnt == LAST_COL) begin
                  r_state  <= ST_IDLE;
                  r_rd_cnt <= '0;
                  r_rd_sel <= r_rd_sel + SEL_ONE;
                  r_intr   <= 1'b1;
               end else begin
                  r_rd_cnt <= r_rd_cnt + PTR_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output window straight from the buffers, zeroed outside a line read.
   assign pixel_out       = w_rd ? {w_win[r_rd_sel], w_win[w_sel_mid], w_win[w_sel_bot]}
                                 : '0;
   assign pixel_out_valid = w_rd;
   assign intr            = r_intr;
   assign overflow        = r_overflow;

endmodule

// File: tb/tb_image_control.sv
// Bench for image_control: two instances (512-pixel lines and 16-pixel lines)
// share one stimulus stream; a line-buffer reference model predicts every
// output cycle by cycle, with directed checks on the documented corner points.
module tb_image_control;

   localparam int PIX_W = 8;
   localparam int W0    = 512;
   localparam int W1    = 16;
   localparam int OUT_W = 9 * PIX_W;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [PIX_W-1:0] pixel_in = '0;
   logic pixel_in_valid = 1'b0;

   always #5 clk = ~clk;

   logic [OUT_W-1:0] po0, po1;
   logic pv0, pv1, in0, in1, ov0, ov1;

   image_control #(.IMG_WIDTH(W0), .PIX_W(PIX_W)) u_dut0 (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .pixel_out(po0), .pixel_out_valid(pv0), .intr(in0), .overflow(ov0)
   );

   image_control #(.IMG_WIDTH(W1), .PIX_W(PIX_W)) u_dut1 (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
      .pixel_out(po1), .pixel_out_valid(pv1), .intr(in1), .overflow(ov1)
   );

   // ---------------- reference model ----------------
   // Four line stores per instance plus the bookkeeping the documented rules
   // describe: column/line write position, stored-pixel count, and which line
   // (if any) is currently being streamed out and at which column.
   logic [PIX_W-1:0] m_mem [2][4][W0];
   int m_wr_col [2];
   int m_wr_line[2];
   int m_total  [2];
   int m_rd_col [2];
   int m_rd_line[2];
   bit m_reading[2];
   bit m_intr   [2];
   bit m_ovf    [2];

   // ---------------- scoreboard ----------------
   logic [OUT_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cnt_valid0 = 0;
   int cnt_intr0  = 0;

   task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic int dut_w(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   // Window the model expects: lines L, L+1, L+2 of the ring, columns c..c+2 wrapped.
   function automatic logic [OUT_W-1:0] model_window(input int i);
      logic [OUT_W-1:0] win;
      int w;
      win = '0;
      w = dut_w(i);
      if (m_reading[i]) begin
         for (int ln = 0; ln < 3; ln++) begin
            for (int k = 0; k < 3; k++) begin
               win = {win[OUT_W-PIX_W-1:0], m_mem[i][(m_rd_line[i] + ln) % 4][(m_rd_col[i] + k) % w]};
            end
         end
      end
      return win;
   endfunction

   task automatic model_reset(input int i);
      m_wr_col[i]  = 0;
      m_wr_line[i] = 0;
      m_total[i]   = 0;
      m_rd_col[i]  = 0;
      m_rd_line[i] = 0;
      m_reading[i] = 1'b0;
      m_intr[i]    = 1'b0;
      m_ovf[i]     = 1'b0;
   endtask

   // Advance the model by one clock edge given the inputs for that edge,
   // then queue the pixel_out expected during the following cycle.
   task automatic model_update(input logic r, input logic v, input logic [PIX_W-1:0] d);
      for (int i = 0; i < 2; i++) begin
         int w;
         bit reading_now, full, acc;
         int next_total;
         w = dut_w(i);
         if (r) begin
            model_reset(i);
         end else begin
            reading_now = m_reading[i];
            full = (m_total[i] == 4 * w) && !reading_now;
            acc  = v && !full;
            if (v && full) m_ovf[i] = 1'b1;
            next_total = m_total[i] + (acc ? 1 : 0) - (reading_now ? 1 : 0);
            if (acc) begin
               m_mem[i][m_wr_line[i]][m_wr_col[i]] = d;
               m_wr_col[i]++;
               if (m_wr_col[i] == w) begin
                  m_wr_col[i]  = 0;
                  m_wr_line[i] = (m_wr_line[i] + 1) % 4;
               end
            end
            m_intr[i] = 1'b0;
            if (!reading_now) begin
               m_reading[i] = (m_total[i] >= 3 * w);
            end else if (m_rd_col[i] == w - 1) begin
               m_reading[i] = 1'b0;
               m_rd_col[i]  = 0;
               m_rd_line[i] = (m_rd_line[i] + 1) % 4;
               m_intr[i]    = 1'b1;
            end else begin
               m_rd_col[i]++;
            end
            m_total[i] = next_total;
         end
         exp_q.push_back(model_window(i));
      end
   endtask

   // Compare both instances against the model for the current cycle.
   task automatic check_outputs();
      logic [OUT_W-1:0] e, o_po;
      logic o_pv, o_in, o_ov;
      for (int i = 0; i < 2; i++) begin
         o_po = (i == 0) ? po0 : po1;
         o_pv = (i == 0) ? pv0 : pv1;
         o_in = (i == 0) ? in0 : in1;
         o_ov = (i == 0) ? ov0 : ov1;
         e = exp_q.pop_front();
         chk($sformatf("pixel_out%0d", i), o_po, e);
         chk($sformatf("valid%0d", i), OUT_W'(o_pv), OUT_W'(m_reading[i]));
         chk($sformatf("intr%0d", i), OUT_W'(o_in), OUT_W'(m_intr[i]));
         chk($sformatf("overflow%0d", i), OUT_W'(o_ov), OUT_W'(m_ovf[i]));
      end
      cnt_valid0 += int'(pv0);
      cnt_intr0  += int'(in0);
   endtask

   // ---------------- driver ----------------
   // One cycle: sample at the falling edge, then drive inputs for the next rising edge.
   task automatic step(input logic r, input logic v, input logic [PIX_W-1:0] d);
      @(negedge clk);
      check_outputs();
      rst            = r;
      pixel_in_valid = v;
      pixel_in       = d;
      model_update(r, v, d);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0);
   endtask

   // Raster pattern: value = line*16 + col (+ offset), modulo 256.
   task automatic feed_pattern(input int n, input int offset);
      for (int p = 0; p < n; p++) step(1'b0, 1'b1, PIX_W'((p / W0) * 16 + (p % W0) + offset));
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      bit found;
      for (int i = 0; i < 2; i++) model_reset(i);
      exp_q.push_back('0);
      exp_q.push_back('0);
      repeat (3) @(posedge clk);

      // Reset state
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // Three lines of the raster pattern, then the single line read it triggers
      cnt_valid0 = 0;
      cnt_intr0  = 0;
      feed_pattern(3 * W0, 0);
      step(1'b0, 1'b0, '0);
      chk("no_valid_after_fill_edge", OUT_W'(pv0), '0);
      step(1'b0, 1'b0, '0);
      chk("first_valid", OUT_W'(pv0), OUT_W'(1));
      chk("first_window", po0, 72'h000102_101112_202122);
      idle(W0 - 1);
      chk("edge_top_line", OUT_W'(po0[71:48]), OUT_W'(24'hFF0001));
      step(1'b0, 1'b0, '0);
      chk("intr_after_read", OUT_W'(in0), OUT_W'(1));
      idle(700);
      chk("valid_cycles_one_line", OUT_W'(cnt_valid0), OUT_W'(W0));
      chk("intr_pulses_one_line", OUT_W'(cnt_intr0), OUT_W'(1));

      // Continuous random stream of 8 lines, then bursty random traffic
      for (int p = 0; p < 8 * W0; p++) step(1'b0, 1'b1, PIX_W'($urandom));
      for (int p = 0; p < 1500; p++)
         step(1'b0, ($urandom_range(0, 3) != 0), PIX_W'($urandom));
      idle(1200);

      // Reset in the middle of a line read, then refill from buffer 0
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      feed_pattern(3 * W0, 8'h80);
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         if (m_reading[0] && m_rd_col[0] == 200) found = 1'b1;
         else step(1'b0, 1'b0, '0);
      end
      chk("reached_read_col_200", OUT_W'(found), OUT_W'(1));
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("rst_mid_read_valid", OUT_W'(pv0), '0);
      chk("rst_mid_read_pixel", po0, '0);
      chk("rst_mid_read_intr", OUT_W'(in0), '0);
      feed_pattern(3 * W0, 8'h40);
      idle(700);

      // Overflow: saturate the 16-pixel instance with a continuous stream
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      for (int p = 0; p < 600; p++) step(1'b0, 1'b1, PIX_W'($urandom));
      idle(50);
      chk("overflow_sticky_small", OUT_W'(ov1), OUT_W'(1));
      chk("no_overflow_wide", OUT_W'(ov0), '0);
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("overflow_cleared_by_rst", OUT_W'(ov1), '0);
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
